// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: per-stage enables and bubbles for load-use,
// branch redirect, data-memory wait and multi-cycle execute, plus perf counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_use_hazard,
  input  logic                 ex_branch_taken,
  input  logic                 ex_mc_start,
  input  logic                 mc_done,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 mc_go,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic                 mc_timeout
);

  localparam int unsigned MCW = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_MC_WAIT  = 2'd2,
    S_RSVD     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic [MCW-1:0]       mc_cnt_q, mc_cnt_d;
  logic                 tmo_q, tmo_d;

  // en_c: {pc, if_id, id_ex, ex_mem, mem_wb}; fl_c: {if_id, id_ex, ex_mem}
  logic [4:0] en_c;
  logic [2:0] fl_c;
  logic       go_c;
  logic       run_c;
  logic       flush_inc_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      stall_q  <= '0;
      flush_q  <= '0;
      mc_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      mc_cnt_q <= mc_cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    en_c        = '0;
    fl_c        = '0;
    go_c        = 1'b0;
    run_c       = 1'b0;
    flush_inc_c = 1'b0;
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    tmo_d       = tmo_q;
    stall_d     = stall_q;
    flush_d     = flush_q;

    case (state_q)
      S_MEM_WAIT: begin
        if (mem_ready) run_c = 1'b1;
      end
      S_MC_WAIT: begin
        if (mc_done) begin
          en_c    = 5'b11111;
          state_d = S_RUN;
        end else begin
          // EX holds the op while a bubble drains into MEM
          en_c = 5'b00011;
          fl_c = 3'b001;
          if (mc_cnt_q < MCW'(MC_TIMEOUT)) mc_cnt_d = mc_cnt_q + MCW'(1);
          if (mc_cnt_q == MCW'(MC_TIMEOUT - 1)) tmo_d = 1'b1;
        end
      end
      default: begin
        if (mem_req && !mem_ready) state_d = S_MEM_WAIT;
        else                       run_c   = 1'b1;
      end
    endcase

    // Shared RUN decision, also used on the cycle memory completes
    if (run_c) begin
      state_d = S_RUN;
      if (ex_mc_start) begin
        go_c     = 1'b1;
        en_c     = 5'b00011;
        fl_c     = 3'b001;
        state_d  = S_MC_WAIT;
        mc_cnt_d = '0;
      end else if (ex_branch_taken) begin
        en_c        = 5'b11111;
        fl_c        = 3'b110;
        flush_inc_c = 1'b1;
      end else if (load_use_hazard) begin
        en_c = 5'b00111;
        fl_c = 3'b010;
      end else begin
        en_c = 5'b11111;
      end
    end

    if (!en_c[4] && (stall_q != {CNT_WIDTH{1'b1}})) stall_d = stall_q + CNT_WIDTH'(1);
    if (flush_inc_c && (flush_q != {CNT_WIDTH{1'b1}})) flush_d = flush_q + CNT_WIDTH'(1);
  end

  // Controls are forced low while reset is held
  assign pc_en        = rst_n & en_c[4];
  assign if_id_en     = rst_n & en_c[3];
  assign id_ex_en     = rst_n & en_c[2];
  assign ex_mem_en    = rst_n & en_c[1];
  assign mem_wb_en    = rst_n & en_c[0];
  assign if_id_flush  = rst_n & fl_c[2];
  assign id_ex_flush  = rst_n & fl_c[1];
  assign ex_mem_flush = rst_n & fl_c[0];
  assign mc_go        = rst_n & go_c;

  assign state        = state_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign mc_timeout   = tmo_q;

endmodule
